// File: rtl/key_matrix_scan.sv
// Row-scanned matrix keypad: drives one active-low row per slot and debounces whole frames.
// Each new press becomes one event in a single-entry valid/ready register with a sticky overrun flag.
module key_matrix_scan #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 75000,
  parameter int DEBOUNCE_CNT = 3,
  localparam int NKEYS       = ROWS * COLS,
  localparam int CW          = $clog2(NKEYS)
) (
  input  logic             BJ_CLK,
  input  logic             RESET_N,
  input  logic [COLS-1:0]  COL_IN,
  output logic [ROWS-1:0]  ROW_OUT,
  output logic [CW-1:0]    KEY_CODE,
  output logic             KEY_VALID,
  input  logic             KEY_READY,
  output logic [NKEYS-1:0] KEY_MAP,
  output logic             KEY_DOWN,
  output logic             OVERRUN,
  input  logic             OVR_CLR
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(ROWS);
  localparam int SW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  typedef enum logic [1:0] {SCAN, EVAL, EMIT} state_t;

  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    row_next;
  logic [NKEYS-1:0] frame;
  logic [NKEYS-1:0] last_frame;
  logic [NKEYS-1:0] new_keys;
  logic [SW-1:0]    stable_cnt;
  logic [SW-1:0]    stable_next;
  logic             qualify;
  logic [CW-1:0]    first_code;
  logic             accept;

  assign tick     = (tick_cnt == TW'(SCAN_DIV - 1));
  assign row_next = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
  assign accept   = KEY_VALID & KEY_READY;
  assign KEY_DOWN = |KEY_MAP;

  // Free-running slot timer; it keeps counting through EVAL/EMIT so the row rate never stretches.
  always_ff @(posedge BJ_CLK or negedge RESET_N) begin
    if (!RESET_N)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  // stable_cnt saturates at DEBOUNCE_CNT-1, so once a frame qualifies it keeps
  // qualifying; repeats are harmless because KEY_MAP already equals the frame.
  always_comb begin
    stable_next = '0;
    if (frame == last_frame)
      stable_next = (stable_cnt == SW'(DEBOUNCE_CNT - 1)) ? stable_cnt : stable_cnt + SW'(1);
  end

  assign qualify = (stable_next == SW'(DEBOUNCE_CNT - 1));

  always_comb begin
    first_code = '0;
    for (int i = NKEYS - 1; i >= 0; i--)
      if (new_keys[i])
        first_code = CW'(i);
  end

  always_ff @(posedge BJ_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= SCAN;
      row_idx    <= '0;
      ROW_OUT    <= {{(ROWS-1){1'b1}}, 1'b0};
      frame      <= '0;
      last_frame <= '0;
      new_keys   <= '0;
      stable_cnt <= '0;
      KEY_MAP    <= '0;
      KEY_VALID  <= 1'b0;
      KEY_CODE   <= '0;
      OVERRUN    <= 1'b0;
    end else begin
      if (accept)
        KEY_VALID <= 1'b0;
      if (OVR_CLR)
        OVERRUN <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            frame[row_idx*COLS +: COLS] <= ~COL_IN;
            row_idx <= row_next;
            ROW_OUT <= ~(ROWS'(1) << row_next);
            if (row_idx == RW'(ROWS - 1))
              state <= EVAL;
          end
        end
        EVAL: begin
          stable_cnt <= stable_next;
          last_frame <= frame;
          state      <= SCAN;
          if (qualify) begin
            new_keys <= frame & ~KEY_MAP;
            KEY_MAP  <= frame;
            if ((frame & ~KEY_MAP) != '0)
              state <= EMIT;
          end
        end
        EMIT: begin
          // A slot freed by this cycle's handshake may be reloaded; otherwise the press is lost.
          if (!KEY_VALID || KEY_READY) begin
            KEY_CODE  <= first_code;
            KEY_VALID <= 1'b1;
          end else begin
            OVERRUN <= 1'b1;
          end
          state <= SCAN;
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan: a keypad emulator plus a frame-level reference model,
// table vectors, hand-written corner sequences and a randomized phase.
module tb_key_matrix_scan;

  localparam int ROWS         = 4;
  localparam int COLS         = 4;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int NK           = ROWS * COLS;
  localparam int CW           = $clog2(NK);
  localparam int FRAME        = SCAN_DIV * ROWS;

  logic            BJ_CLK    = 1'b0;
  logic            RESET_N   = 1'b1;
  logic [COLS-1:0] COL_IN    = '1;
  logic [ROWS-1:0] ROW_OUT;
  logic [CW-1:0]   KEY_CODE;
  logic            KEY_VALID;
  logic            KEY_READY = 1'b0;
  logic [NK-1:0]   KEY_MAP;
  logic            KEY_DOWN;
  logic            OVERRUN;
  logic            OVR_CLR   = 1'b0;

  key_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .BJ_CLK(BJ_CLK), .RESET_N(RESET_N), .COL_IN(COL_IN), .ROW_OUT(ROW_OUT),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_READY(KEY_READY),
    .KEY_MAP(KEY_MAP), .KEY_DOWN(KEY_DOWN), .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
  );

  always #5 BJ_CLK = ~BJ_CLK;

  int checks   = 0;
  int failures = 0;

  logic [NK-1:0] pressed = '0;

  // Reference model state: edges since reset, assembled frame, debounce run length, event slot.
  int            m_edges;
  logic [NK-1:0] m_frame, m_prev, m_map, m_new;
  int            m_run;
  logic          m_eval_due, m_emit_due, m_valid, m_ovr;
  logic [CW-1:0] m_code;

  int            hs_count;
  logic [CW-1:0] hs_code;
  logic          seen_valid;
  logic [CW-1:0] seen_code;

  typedef struct {
    logic [NK-1:0] press;
    logic [NK-1:0] exp_map;
    logic          exp_valid;
    logic [CW-1:0] exp_code;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] lowest_index(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++)
      if (v[i]) return CW'(i);
    return '0;
  endfunction

  task automatic model_reset();
    m_edges    = 0;
    m_frame    = '0;
    m_prev     = '0;
    m_map      = '0;
    m_new      = '0;
    m_run      = 1;
    m_eval_due = 1'b0;
    m_emit_due = 1'b0;
    m_valid    = 1'b0;
    m_ovr      = 1'b0;
    m_code     = '0;
    seen_valid = 1'b0;
    seen_code  = '0;
  endtask

  // One rising edge of the model, driven by the inputs present at that edge.
  task automatic model_edge();
    logic old_valid;
    logic ovr_set;
    int   r;
    m_edges++;
    old_valid = m_valid;
    ovr_set   = 1'b0;
    if (m_valid && KEY_READY)
      m_valid = 1'b0;
    if (m_emit_due) begin
      m_emit_due = 1'b0;
      if (!old_valid || KEY_READY) begin
        m_code  = lowest_index(m_new);
        m_valid = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (ovr_set)
      m_ovr = 1'b1;
    else if (OVR_CLR)
      m_ovr = 1'b0;
    if (m_eval_due) begin
      m_eval_due = 1'b0;
      if (m_frame == m_prev) m_run++;
      else m_run = 1;
      m_prev = m_frame;
      if (m_run >= DEBOUNCE_CNT) begin
        m_new = m_frame & ~m_map;
        m_map = m_frame;
        if (m_new != '0) m_emit_due = 1'b1;
      end
    end
    if (m_edges % SCAN_DIV == 0) begin
      r = (m_edges / SCAN_DIV - 1) % ROWS;
      m_frame[r*COLS +: COLS] = pressed[r*COLS +: COLS];
      if (r == ROWS - 1) m_eval_due = 1'b1;
    end
  endtask

  task automatic check_model();
    logic [ROWS-1:0] er;
    er = '1;
    er[(m_edges / SCAN_DIV) % ROWS] = 1'b0;
    check_output("row_out",   32'(ROW_OUT),   32'(er));
    check_output("key_map",   32'(KEY_MAP),   32'(m_map));
    check_output("key_down",  32'(KEY_DOWN),  32'(m_map != '0));
    check_output("key_valid", 32'(KEY_VALID), 32'(m_valid));
    check_output("key_code",  32'(KEY_CODE),  32'(m_code));
    check_output("overrun",   32'(OVERRUN),   32'(m_ovr));
  endtask

  // The emulated keypad answers the row the model expects to be driven.
  task automatic step_cycle();
    int r;
    r = (m_edges / SCAN_DIV) % ROWS;
    COL_IN = ~pressed[r*COLS +: COLS];
    @(posedge BJ_CLK);
    if (seen_valid && KEY_READY) begin
      hs_count++;
      hs_code = seen_code;
    end
    model_edge();
    #2;
    check_model();
    seen_valid = KEY_VALID;
    seen_code  = KEY_CODE;
  endtask

  task automatic apply_stimulus(input logic [NK-1:0] p, input int cycles);
    pressed = p;
    for (int i = 0; i < cycles; i++)
      step_cycle();
  endtask

  task automatic do_reset();
    #1;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_model();
    check_output("rst_row_out", 32'(ROW_OUT),   32'h0000_000e);
    check_output("rst_valid",   32'(KEY_VALID), 32'h0);
    check_output("rst_map",     32'(KEY_MAP),   32'h0);
    check_output("rst_overrun", 32'(OVERRUN),   32'h0);
    @(negedge BJ_CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [ROWS-1:0] walk[4];
    logic [NK-1:0]   p;
    int              k;
    int              n;

    vecs[0] = '{press: 16'h0200, exp_map: 16'h0200, exp_valid: 1'b1, exp_code: 4'd9};
    vecs[1] = '{press: 16'h0000, exp_map: 16'h0000, exp_valid: 1'b0, exp_code: 4'd9};
    vecs[2] = '{press: 16'h1040, exp_map: 16'h1040, exp_valid: 1'b1, exp_code: 4'd6};
    vecs[3] = '{press: 16'h1041, exp_map: 16'h1041, exp_valid: 1'b1, exp_code: 4'd0};
    vecs[4] = '{press: 16'h0001, exp_map: 16'h0001, exp_valid: 1'b0, exp_code: 4'd0};
    vecs[5] = '{press: 16'h8000, exp_map: 16'h8000, exp_valid: 1'b1, exp_code: 4'd15};
    vecs[6] = '{press: 16'h0008, exp_map: 16'h0008, exp_valid: 1'b1, exp_code: 4'd3};
    vecs[7] = '{press: 16'h0000, exp_map: 16'h0000, exp_valid: 1'b0, exp_code: 4'd3};
    walk[0] = 4'b1101;
    walk[1] = 4'b1011;
    walk[2] = 4'b0111;
    walk[3] = 4'b1110;
    hs_count = 0;
    hs_code  = '0;

    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus('0, SCAN_DIV);
      check_output("row_walk", 32'(ROW_OUT), 32'(walk[i]));
    end

    // Table: hold a pattern for four frames with the consumer stalled, then accept for one frame.
    for (int i = 0; i < 8; i++) begin
      KEY_READY = 1'b0;
      apply_stimulus(vecs[i].press, 4 * FRAME);
      check_output("vec_map",   32'(KEY_MAP),   32'(vecs[i].exp_map));
      check_output("vec_valid", 32'(KEY_VALID), 32'(vecs[i].exp_valid));
      check_output("vec_code",  32'(KEY_CODE),  32'(vecs[i].exp_code));
      KEY_READY = 1'b1;
      apply_stimulus(vecs[i].press, 1);
      check_output("vec_valid_drop", 32'(KEY_VALID), 32'h0);
      apply_stimulus(vecs[i].press, FRAME - 1);
      KEY_READY = 1'b0;
      check_output("vec_no_repeat", 32'(KEY_VALID), 32'h0);
    end

    // Bounce on r0c0: alternating frames produce nothing until three identical frames arrive.
    KEY_READY = 1'b1;
    hs_count  = 0;
    for (int i = 0; i < 5; i++)
      apply_stimulus((i % 2 == 0) ? 16'h0001 : 16'h0000, FRAME);
    check_output("bounce_early", 32'(hs_count), 32'd0);
    apply_stimulus(16'h0001, 4 * FRAME);
    check_output("bounce_count", 32'(hs_count), 32'd1);
    check_output("bounce_code",  32'(hs_code),  32'd0);
    apply_stimulus(16'h0000, 4 * FRAME);
    check_output("bounce_release", 32'(hs_count), 32'd1);

    // Overrun: second press arrives while the first event is still unread.
    KEY_READY = 1'b0;
    apply_stimulus(16'h0200, 4 * FRAME);
    apply_stimulus(16'h0000, 4 * FRAME);
    apply_stimulus(16'h0008, 4 * FRAME);
    check_output("ovr_code",  32'(KEY_CODE),  32'd9);
    check_output("ovr_valid", 32'(KEY_VALID), 32'h1);
    check_output("ovr_flag",  32'(OVERRUN),   32'h1);
    check_output("ovr_map",   32'(KEY_MAP),   32'h0008);
    OVR_CLR = 1'b1;
    apply_stimulus(16'h0008, 1);
    OVR_CLR = 1'b0;
    check_output("ovr_clear", 32'(OVERRUN), 32'h0);
    apply_stimulus(16'h0008, FRAME - 1);
    KEY_READY = 1'b1;
    apply_stimulus(16'h0008, FRAME);
    KEY_READY = 1'b0;
    apply_stimulus(16'h0000, 4 * FRAME);

    // Simultaneous r1c2+r3c0 whose EMIT lands on the same edge as the handshake of the old event.
    apply_stimulus(16'h0008, 4 * FRAME);
    check_output("sim_prior_code", 32'(KEY_CODE), 32'd3);
    apply_stimulus(16'h1040, 3 * FRAME + 1);
    KEY_READY = 1'b1;
    apply_stimulus(16'h1040, 1);
    KEY_READY = 1'b0;
    check_output("sim_code",    32'(KEY_CODE),  32'd6);
    check_output("sim_valid",   32'(KEY_VALID), 32'h1);
    check_output("sim_overrun", 32'(OVERRUN),   32'h0);
    apply_stimulus(16'h1040, FRAME - 2);
    check_output("sim_map", 32'(KEY_MAP), 32'h1040);
    KEY_READY = 1'b1;
    apply_stimulus(16'h1040, FRAME);
    KEY_READY = 1'b0;
    apply_stimulus(16'h0000, 4 * FRAME);

    // Reset while row 2 is driven, with a key already in the debounced map.
    KEY_READY = 1'b1;
    apply_stimulus(16'h0001, 4 * FRAME);
    check_output("mid_map_before", 32'(KEY_MAP), 32'h0001);
    apply_stimulus(16'h0001, 2 * SCAN_DIV);
    check_output("mid_row2", 32'(ROW_OUT), 32'h0000_000b);
    do_reset();
    KEY_READY = 1'b0;
    apply_stimulus(16'h0000, 2 * FRAME);
    check_output("mid_map_after",   32'(KEY_MAP),   32'h0);
    check_output("mid_valid_after", 32'(KEY_VALID), 32'h0);

    // Randomized phase: sparse key patterns held for unaligned spans, random consumer behaviour.
    do_reset();
    for (int s = 0; s < 150; s++) begin
      p = '0;
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++)
        p[$urandom_range(0, NK - 1)] = 1'b1;
      pressed = p;
      n = $urandom_range(8, 70);
      for (int c = 0; c < n; c++) begin
        KEY_READY = ($urandom_range(0, 2) == 0);
        OVR_CLR   = ($urandom_range(0, 19) == 0);
        step_cycle();
      end
    end
    KEY_READY = 1'b0;
    OVR_CLR   = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
